// File: rtl/debug_probe_scanner.sv
// Debug-view sequencer: picks one of NCH probe words by auto-scan, single-step,
// direct select or frozen snapshot, and tags the shown word with its channel index.
module debug_probe_scanner #(
  parameter  int NCH   = 8,
  parameter  int DW    = 32,
  parameter  int TAG_W = 4,
  parameter  int DIV_W = 28,
  localparam int IDX_W = (NCH > 2) ? $clog2(NCH) : 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                en_i,
  input  logic [1:0]          mode_i,
  input  logic                freeze_i,
  input  logic                step_i,
  input  logic [IDX_W-1:0]    sel_i,
  input  logic [DIV_W-1:0]    period_i,
  input  logic [NCH*DW-1:0]   probe_i,
  output logic [DW-1:0]       data_o,
  output logic [IDX_W-1:0]    idx_o,
  output logic                valid_o,
  output logic                wrap_o
);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
  typedef enum logic [1:0] {
    M_AUTO   = 2'b00,
    M_STEP   = 2'b01,
    M_DIRECT = 2'b10,
    M_SNAP   = 2'b11
  } mode_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NCH - 1);

  state_t              state, state_nxt;
  mode_t               mode;
  logic                active;
  logic [DIV_W-1:0]    cnt, per;
  logic                tick, stp, step_q;
  logic                adv, capture;
  logic [NCH*DW-1:0]   bank;
  logic [DW-1:0]       live_word, bank_word, src_word;
  logic [IDX_W-1:0]    idx, sel_clamp;
  logic                unused_tag_bits;

  assign mode  = mode_t'(mode_i);
  assign idx_o = idx;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = SCAN;
        SCAN:    if (freeze_i)  state_nxt = HOLD;
        HOLD:    if (!freeze_i) state_nxt = SCAN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // freeze_i gates updates at its level, so holding and releasing take effect
  // on the very edge that sees it rather than one cycle late.
  always_comb begin
    valid_o = en_i && (state != IDLE);
    active  = en_i && !freeze_i && (state != IDLE);
  end

  assign per  = (period_i == '0) ? DIV_W'(1) : period_i;
  assign tick = active && (cnt == per - DIV_W'(1));
  assign stp  = step_i & ~step_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                   cnt <= '0;
    else if (!active)            cnt <= '0;
    else if (tick || cnt >= per) cnt <= '0;
    else                         cnt <= cnt + DIV_W'(1);
  end

  always_comb begin
    live_word = '0;
    bank_word = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (idx == IDX_W'(k)) begin
        live_word = probe_i[k*DW +: DW];
        bank_word = bank[k*DW +: DW];
      end
    end
  end

  assign src_word        = (mode == M_SNAP) ? bank_word : live_word;
  assign sel_clamp       = (sel_i > LAST) ? LAST : sel_i;
  assign unused_tag_bits = ^src_word[DW-1:DW-TAG_W];

  always_comb begin
    adv     = 1'b0;
    capture = 1'b0;
    if (active) begin
      case (mode)
        M_AUTO:  adv = tick;
        M_STEP:  adv = stp;
        M_SNAP: begin
          capture = stp;
          adv     = tick && !stp;
        end
        default: adv = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx    <= '0;
      data_o <= '0;
      wrap_o <= 1'b0;
      bank   <= '0;
      step_q <= 1'b0;
    end else begin
      step_q <= step_i;
      wrap_o <= 1'b0;
      if (!en_i) begin
        idx    <= '0;
        data_o <= '0;
      end else if (active) begin
        data_o <= {TAG_W'(idx), src_word[DW-TAG_W-1:0]};
        if (capture) begin
          bank <= probe_i;
          idx  <= '0;
        end else if (mode == M_DIRECT) begin
          idx <= sel_clamp;
        end else if (adv) begin
          if (idx == LAST) begin
            idx    <= '0;
            wrap_o <= 1'b1;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_debug_probe_scanner.sv
// Bench for debug_probe_scanner: a 4-channel and a 3-channel build run off shared
// stimulus, checked every cycle against a behavioural model plus literal spot values.
module tb_debug_probe_scanner;

  logic         clk = 1'b0;
  logic         rstn;
  logic         en, freeze, step;
  logic [1:0]   mode;
  logic [1:0]   sel;
  logic [7:0]   period;
  logic [127:0] probe;

  logic [31:0]  data_o, data3;
  logic [1:0]   idx_o, idx3;
  logic         valid_o, valid3, wrap_o, wrap3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debug_probe_scanner #(.NCH(4), .DW(32), .TAG_W(4), .DIV_W(8)) dut (
    .clk(clk), .rstn(rstn), .en_i(en), .mode_i(mode), .freeze_i(freeze),
    .step_i(step), .sel_i(sel), .period_i(period), .probe_i(probe),
    .data_o(data_o), .idx_o(idx_o), .valid_o(valid_o), .wrap_o(wrap_o)
  );

  debug_probe_scanner #(.NCH(3), .DW(32), .TAG_W(4), .DIV_W(8)) dut3 (
    .clk(clk), .rstn(rstn), .en_i(en), .mode_i(mode), .freeze_i(freeze),
    .step_i(step), .sel_i(sel), .period_i(period), .probe_i(probe[95:0]),
    .data_o(data3), .idx_o(idx3), .valid_o(valid3), .wrap_o(wrap3)
  );

  typedef struct packed {
    bit             on;
    int             cnt;
    int             idx;
    bit [31:0]      data;
    bit             wrap;
    bit             sq;
    bit [3:0][31:0] bank;
  } ms_t;

  ms_t m4 = '0, m3 = '0, n4, n3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of the scanner as described: returns the state after the edge.
  function automatic ms_t mstep(input ms_t s, input int nch, input bit e, input bit fr,
                                input bit st, input bit [1:0] md, input int sl,
                                input int per_in, input bit [127:0] pr);
    ms_t n = s;
    int per;
    bit tick = 0, adv = 0, stp;
    bit [31:0] src;
    stp    = st && !s.sq;
    n.sq   = st;
    n.wrap = 0;
    if (!e) begin
      n.on = 0; n.cnt = 0; n.idx = 0; n.data = 0;
      return n;
    end
    if (!s.on) begin
      n.on = 1;
      return n;
    end
    if (fr) begin
      n.cnt = 0;
      return n;
    end
    per = (per_in == 0) ? 1 : per_in;
    if (s.cnt >= per) n.cnt = 0;
    else if (s.cnt == per - 1) begin tick = 1; n.cnt = 0; end
    else n.cnt = s.cnt + 1;
    src    = (md == 2'b11) ? s.bank[s.idx] : pr[s.idx*32 +: 32];
    n.data = (32'(s.idx) << 28) | (src & 32'h0FFF_FFFF);
    case (md)
      2'b00: adv = tick;
      2'b01: adv = stp;
      2'b10: n.idx = (sl >= nch) ? nch - 1 : sl;
      default: begin
        if (stp) begin
          for (int k = 0; k < 4; k++) n.bank[k] = pr[k*32 +: 32];
          n.idx = 0;
        end else adv = tick;
      end
    endcase
    if (adv) begin
      if (s.idx == nch - 1) begin n.idx = 0; n.wrap = 1; end
      else n.idx = s.idx + 1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      n4 = '0;
      n3 = '0;
    end else begin
      n4 = mstep(m4, 4, en, freeze, step, mode, int'(sel), int'(period), probe);
      n3 = mstep(m3, 3, en, freeze, step, mode, int'(sel), int'(period), {32'h0, probe[95:0]});
    end
    #2;
    m4 = n4;
    m3 = n3;
    check("data4",  data_o,  m4.data);
    check("idx4",   32'(idx_o), 32'(m4.idx));
    check("wrap4",  32'(wrap_o), 32'(m4.wrap));
    check("valid4", 32'(valid_o), 32'(en && m4.on));
    check("data3",  data3,  m3.data);
    check("idx3",   32'(idx3), 32'(m3.idx));
    check("wrap3",  32'(wrap3), 32'(m3.wrap));
    check("valid3", 32'(valid3), 32'(en && m3.on));
  end

  task automatic wait_idx(input int v, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (int'(idx_o) != v && n < 40);
    check("reach_idx", 32'(idx_o), 32'(v));
  endtask

  task automatic set_probes_default();
    for (int k = 0; k < 4; k++) probe[k*32 +: 32] = 32'hA000_0000 + 32'(k);
  endtask

  initial begin
    int n;
    logic [31:0] d0;
    logic [1:0]  i0;
    rstn = 1'b0; en = 1'b0; freeze = 1'b0; step = 1'b0;
    mode = 2'b00; sel = 2'd0; period = 8'd3;
    set_probes_default();
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_data",  data_o, 32'h0);
      check("idle_idx",   32'(idx_o), 32'h0);
      check("idle_valid", 32'(valid_o), 32'h0);
    end

    en = 1'b1; mode = 2'b00; period = 8'd3;
    wait_idx(1, n);
    wait_idx(2, n);
    check("auto_space_12", n, 3);
    wait_idx(3, n);
    check("auto_space_23", n, 3);
    check("auto_data_idx2", data_o, 32'h2000_0002);
    wait_idx(0, n);
    check("auto_space_30", n, 3);
    check("auto_wrap_hi", 32'(wrap_o), 32'h1);

    mode = 2'b01;
    @(negedge clk);
    check("auto_wrap_lo", 32'(wrap_o), 32'h0);
    for (int p = 0; p < 2; p++) begin
      step = 1'b1; @(negedge clk);
      step = 1'b0; @(negedge clk);
    end
    check("step_after2", 32'(idx_o), 32'h2);
    step = 1'b1;
    repeat (5) @(negedge clk);
    step = 1'b0;
    repeat (4) @(negedge clk);
    check("step_held_once", 32'(idx_o), 32'h3);

    mode = 2'b10; sel = 2'd1;
    repeat (2) @(negedge clk);
    check("direct_data1", data_o, 32'h1000_0001);
    sel = 2'd3;
    @(negedge clk);
    check("direct_idx3", 32'(idx_o), 32'h3);
    @(negedge clk);
    check("direct_data3", data_o, 32'h3000_0003);
    check("nch3_clamp_idx", 32'(idx3), 32'h2);
    check("nch3_clamp_data", data3, 32'h2000_0002);

    mode = 2'b11; period = 8'd3; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check("snap_capture_idx", 32'(idx_o), 32'h0);
    for (int k = 0; k < 4; k++) probe[k*32 +: 32] = 32'hFFFF_FFFF;
    wait_idx(2, n);
    check("snap_data1", data_o, 32'h1000_0001);
    wait_idx(3, n);
    check("snap_data2", data_o, 32'h2000_0002);
    n = 0;
    while (!(m4.cnt == 2 && (m4.idx == 1 || m4.idx == 2)) && n < 20) begin
      @(negedge clk); n++;
    end
    check("coinc_setup_found", 32'(n < 20), 32'h1);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check("coinc_capture_wins", 32'(idx_o), 32'h0);
    set_probes_default();

    mode = 2'b00; period = 8'd3;
    repeat (5) @(negedge clk);
    d0 = data_o; i0 = idx_o;
    freeze = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step = (i % 4 == 1);
      @(negedge clk);
      check("freeze_data", data_o, d0);
      check("freeze_idx", 32'(idx_o), 32'(i0));
    end
    freeze = 1'b0; step = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (idx_o == i0 && n < 40);
    check("release_first_adv", n, 3);

    for (int i = 0; i < 400; i++) begin
      en     = ($urandom_range(0, 19) != 0);
      freeze = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) step = ~step;
      sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) period = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0) probe[$urandom_range(0, 3)*32 +: 32] = $urandom;
      @(negedge clk);
    end

    en = 1'b1; mode = 2'b00; period = 8'd2; freeze = 1'b0; step = 1'b0;
    set_probes_default();
    repeat (7) @(negedge clk);
    check("pre_reset_valid", 32'(valid_o), 32'h1);
    #3 rstn = 1'b0;
    #1;
    check("async_data",   data_o, 32'h0);
    check("async_idx",    32'(idx_o), 32'h0);
    check("async_valid",  32'(valid_o), 32'h0);
    check("async_wrap",   32'(wrap_o), 32'h0);
    check("async_data3",  data3, 32'h0);
    check("async_valid3", 32'(valid3), 32'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
